dff_reset_styles: RTL and testbench
===================================

Name: dff_reset_styles

Overview:
- Reference block of three D flip-flops driven by the same clock and data input.
- Each flop uses a different reset style:
  - no reset
  - synchronous active-low reset
  - asynchronous active-low reset
- Used as a teaching/verification primitive, and as a template for choosing reset styles elsewhere in the design.
- Purely sequential, no handshake.

Parameters:
- WIDTH, 1, width of d_i and of each q output.
- RST_VAL, 0 (WIDTH bits), value loaded into q_syncrst_o and q_asyncrst_o on reset.

Ports:
- clk  input  1  single clock; all flops rising-edge triggered.
- reset  input  1  asynchronous active-low reset; may assert or deassert at any time, not clock-aligned.
- d_i  input  WIDTH  data input shared by all three flops.
- q_norst_o  output  WIDTH  flop with no reset.
- q_syncrst_o  output  WIDTH  flop with synchronous active-low reset.
- q_asyncrst_o  output  WIDTH  flop with asynchronous active-low reset.

Behaviour:
- q_norst_o:
  - On every rising clk edge, q_norst_o <= d_i.
  - The reset input has no effect at any time.
  - Power-up value is undefined (X in simulation) until the first rising clk edge.
- q_syncrst_o:
  - Evaluated on every rising clk edge: if reset==0, q_syncrst_o <= RST_VAL; otherwise q_syncrst_o <= d_i.
  - Reset assertion between edges does not change the output until the next rising edge.
  - Power-up value is undefined until the first rising edge.
- q_asyncrst_o:
  - While reset==0, q_asyncrst_o = RST_VAL, forced immediately (combinational path from reset, no clock needed) and held regardless of clk and d_i.
  - On a rising clk edge with reset==1, q_asyncrst_o <= d_i.
  - Reset deassertion is not synchronized inside the block. The first capture of d_i happens on the first rising edge after reset returns high.
  - Reset release must meet the flop recovery time relative to clk.
- Latency: one clk cycle from d_i to every q output. No combinational path from d_i to any output.
- Reset during operation:
  - q_asyncrst_o clears at the moment reset falls.
  - q_syncrst_o clears at the next rising edge.
  - q_norst_o keeps tracking d_i.
- Reset deasserted before the next edge: q_syncrst_o never sees the reset and loads d_i at that edge. q_asyncrst_o still holds RST_VAL until that edge.
- Each output is driven by exactly one always block of the matching style. No gating or enables.

Test Plan:
- Power-up and async reset (WIDTH=1, clk period 10 with first rising edge at t=5). Hold reset=0 and d_i=1 at t=0, release reset=1 at t=1.
  - q_asyncrst_o=0 from t=0.
  - q_syncrst_o and q_norst_o are X until t=5.
  - At t=5 all three outputs = 1.
- Normal tracking: reset=1, drive d_i with random 0/1 after each of 5 edges.
  - After each edge, all three outputs equal d_i from the previous edge and are identical to each other.
- Synchronous reset: just after the edge at t=55, drive d_i=1 and reset=0.
  - q_asyncrst_o drops to 0 immediately.
  - q_syncrst_o stays at its old value until t=65, then becomes 0.
  - q_norst_o=1 at t=65.
- Reset release: just after t=65, drive reset=1 with d_i=1.
  - q_asyncrst_o and q_syncrst_o hold 0 until t=75, then become 1.
  - q_norst_o stays 1 throughout.
- Short reset pulse between edges: reset low for 2 time units mid-cycle.
  - q_asyncrst_o pulses to 0 and recovers to d_i only at the next edge.
  - q_syncrst_o is unaffected.
  - q_norst_o is unaffected.
- RST_VAL/WIDTH check: WIDTH=4, RST_VAL=4'hA, d_i=4'h5.
  - While reset=0: q_asyncrst_o=4'hA immediately, and q_syncrst_o=4'hA after the next edge.
  - After release: both outputs become 4'h5.

Source files
------------

// File: rtl/dff_reset_styles.sv
// dff_reset_styles
// Three D flip-flops share one clock and one data input. Each flop uses a
// different reset style, so the block can be used to compare those styles
// side by side:
//   q_norst_o    - no reset; holds X until the first rising clock edge
//   q_syncrst_o  - synchronous active-low reset, sampled at the clock edge
//   q_asyncrst_o - asynchronous active-low reset, forced as soon as reset falls
// Each output comes straight from a flop. d_i has no combinational path to
// any output.
`timescale 1ns/1ps

module dff_reset_styles #(
   parameter int unsigned      WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,        // active-low, not aligned to clk
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_norst_o,
   output logic [WIDTH-1:0] q_syncrst_o,
   output logic [WIDTH-1:0] q_asyncrst_o
);

   // Plain data flop that captures d_i on every edge.
   // NOTE: leaving out the reset is deliberate. This flop only carries data,
   // so no reset net has to reach it. Downstream logic must not rely on its
   // value before the first clock edge.
   always_ff @(posedge clk) begin
      // NOTE: use non-blocking assignments for all flop state, so every flop
      // samples the values from before the edge and the result does not
      // depend on the order in which the blocks are evaluated.
      q_norst_o <= d_i;
   end

   // Flop with synchronous reset: reset is an ordinary data input that is
   // sampled at the edge. A pulse that falls between two edges is not seen.
   always_ff @(posedge clk) begin
      if (!reset) q_syncrst_o <= RST_VAL;
      else        q_syncrst_o <= d_i;
   end

   // Flop with asynchronous reset: the output is forced to RST_VAL as soon as
   // reset goes low. Release is not synchronised in this block, so reset must
   // rise far enough before a clock edge to meet the flop's recovery time.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q_asyncrst_o <= RST_VAL;
      else        q_asyncrst_o <= d_i;
   end

endmodule

// File: tb/tb_dff_reset_styles.sv
// tb_dff_reset_styles
// Two instances are tested: a WIDTH=1 instance with the default reset value,
// and a WIDTH=4 instance with RST_VAL=4'hA. The stimulus process drives the
// inputs and queues each expected output triple at the moment it should hold.
// A separate monitor process takes entries off the queue and compares them
// with the live DUT outputs.
`timescale 1ns/1ps

module tb_dff_reset_styles;

   typedef struct {
      string      name;
      bit         wide;      // 0: WIDTH=1 instance, 1: WIDTH=4 instance
      bit [2:0]   mask;      // [2] norst, [1] syncrst, [0] asyncrst
      logic [3:0] n;
      logic [3:0] s;
      logic [3:0] a;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset1 = 1'b0;
   logic       d1 = 1'b1;
   logic       q_n1, q_s1, q_a1;
   logic       reset4 = 1'b1;
   logic [3:0] d4 = 4'h5;
   logic [3:0] q_n4, q_s4, q_a4;

   exp_t sb[$];
   bit   stim_done = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   // Period 10, with the first rising edge at t=5.
   initial forever #5 clk = ~clk;

   dff_reset_styles #(.WIDTH(1)) dut1 (
      .clk          (clk),
      .reset        (reset1),
      .d_i          (d1),
      .q_norst_o    (q_n1),
      .q_syncrst_o  (q_s1),
      .q_asyncrst_o (q_a1)
   );

   dff_reset_styles #(.WIDTH(4), .RST_VAL(4'hA)) dut4 (
      .clk          (clk),
      .reset        (reset4),
      .d_i          (d4),
      .q_norst_o    (q_n4),
      .q_syncrst_o  (q_s4),
      .q_asyncrst_o (q_a4)
   );

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic expect_now(input string name, input bit wide, input bit [2:0] mask,
                             input logic [3:0] n, input logic [3:0] s, input logic [3:0] a);
      exp_t e;
      e.name = name; e.wide = wide; e.mask = mask;
      e.n = n; e.s = s; e.a = a;
      sb.push_back(e);
   endtask

   // Stimulus: directed vectors, each paired with the outputs expected at that time.
   initial begin
      logic pat [5];
      pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      // Power-up: reset low and d=1 from t=0, reset released at t=1.
      #0.5 expect_now("pwr_async", 0, 3'b001, 4'h0, 4'h0, 4'h0);
      #0.5 reset1 = 1'b1;
      #5   expect_now("first_edge", 0, 3'b111, 4'h1, 4'h1, 4'h1);          // t=6

      // Normal tracking over five edges (t=15..55).
      for (int i = 0; i < 5; i++) begin
         d1 = pat[i];
         #10 expect_now("track", 0, 3'b111, {3'b0, pat[i]}, {3'b0, pat[i]}, {3'b0, pat[i]});
      end                                                                  // t=56

      // Reset asserted mid-cycle: async output clears at once, sync output at the next edge.
      #0.5 d1 = 1'b1; reset1 = 1'b0;                                       // t=56.5
      #0.5 expect_now("srst_async_now", 0, 3'b111, 4'h1, 4'h1, 4'h0);     // t=57
      #7   expect_now("srst_hold",      0, 3'b111, 4'h1, 4'h1, 4'h0);     // t=64
      #2   expect_now("srst_edge",      0, 3'b111, 4'h1, 4'h0, 4'h0);     // t=66

      // Reset released: both reset flops hold 0 until the next edge.
      #0.5 reset1 = 1'b1; d1 = 1'b1;                                       // t=66.5
      #3.5 expect_now("rel_hold", 0, 3'b111, 4'h1, 4'h0, 4'h0);           // t=70
      #6   expect_now("rel_edge", 0, 3'b111, 4'h1, 4'h1, 4'h1);           // t=76

      // Short reset pulse (t=79..81) between the edges at t=75 and t=85.
      #2 d1 = 1'b0;                                                        // t=78
      #1 reset1 = 1'b0;                                                    // t=79
      #1 expect_now("pulse_low",   0, 3'b111, 4'h1, 4'h1, 4'h0);          // t=80
      #1 reset1 = 1'b1;                                                    // t=81
      #2 expect_now("pulse_after", 0, 3'b111, 4'h1, 4'h1, 4'h0);          // t=83
      #3 expect_now("pulse_edge",  0, 3'b111, 4'h0, 4'h0, 4'h0);          // t=86

      // WIDTH=4, RST_VAL=4'hA instance.
      #5   expect_now("w4_run",      1, 3'b111, 4'h5, 4'h5, 4'h5);        // t=91
      #1   reset4 = 1'b0;                                                  // t=92
      #0.5 expect_now("w4_async",    1, 3'b111, 4'h5, 4'h5, 4'hA);        // t=92.5
      #3.5 expect_now("w4_sync",     1, 3'b111, 4'h5, 4'hA, 4'hA);        // t=96
      #1   reset4 = 1'b1;                                                  // t=97
      #3   expect_now("w4_rel_hold", 1, 3'b111, 4'h5, 4'hA, 4'hA);        // t=100
      #6   expect_now("w4_rel_edge", 1, 3'b111, 4'h5, 4'h5, 4'h5);        // t=106
      #1 stim_done = 1'b1;
   end

   // Monitor: takes expected entries off the queue and compares them with the live outputs.
   initial begin
      exp_t e;
      logic [3:0] an, as, aa;
      while (!(stim_done && sb.size() == 0)) begin
         if (sb.size() == 0) begin
            #0.1;
         end else begin
            e = sb.pop_front();
            if (e.wide) begin
               an = q_n4; as = q_s4; aa = q_a4;
            end else begin
               an = {3'b0, q_n1}; as = {3'b0, q_s1}; aa = {3'b0, q_a1};
            end
            if (e.mask[2]) check({e.name, ".norst"},    an, e.n);
            if (e.mask[1]) check({e.name, ".syncrst"},  as, e.s);
            if (e.mask[0]) check({e.name, ".asyncrst"}, aa, e.a);
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog: stops the run if the monitor never drains the queue.
   initial begin
      #5000;
      $display("FAIL watchdog: test did not complete by t=%0t, got %0d pending, expected 0", $time, sb.size());
      $fatal(1, "watchdog expired");
   end

endmodule
